// File: rtl/fft8_core.sv
// 8-point radix-2 DIT FFT: load 8 samples, 12 in-place butterflies, stream 8 bins in natural order.
// Latency: out_valid rises 12 cycles after the last sample is accepted; one bin per cycle after that.
// Backpressure: in_ready only in LOAD; bins hold stable while out_ready is low.
module fft8_core #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W+2:0] out_re,
  output logic signed [DATA_W+2:0] out_im,
  output logic [2:0]               out_index,
  output logic                     busy
);

  localparam int BW = DATA_W + 3;     // buffer width: three stages of growth
  localparam int IW = 2 * BW + 1;     // butterfly product/sum width
  localparam logic signed [IW-1:0] SCALE = IW'(1000);

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] UNLOAD  = 2'd2;

  logic [1:0] state;
  logic [2:0] cnt;      // sample number in LOAD, bin number in UNLOAD
  logic [1:0] stg;      // butterfly stage 0..2
  logic [1:0] bfl;      // butterfly within stage 0..3

  logic signed [BW-1:0] mem_re [8];
  logic signed [BW-1:0] mem_im [8];

  logic [2:0] ld_addr;
  logic [2:0] top, bot, tw_addr;
  logic signed [15:0] tw_re, tw_im;
  logic signed [BW-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [IW-1:0] br_x, bi_x, wr_x, wi_x, sum_re, sum_im;

  // Samples land in bit-reversed slots so the butterflies can run in place.
  assign ld_addr   = {cnt[0], cnt[1], cnt[2]};
  assign in_ready  = (state == LOAD) && !reset;
  assign out_valid = (state == UNLOAD);
  assign busy      = (state == COMPUTE);
  assign out_index = out_valid ? cnt : 3'd0;
  assign out_re    = out_valid ? mem_re[cnt] : '0;
  assign out_im    = out_valid ? mem_im[cnt] : '0;

  // Butterfly addressing: span h = 1<<stg, twiddle index j*(4>>stg).
  always_comb begin
    top     = 3'd0;
    bot     = 3'd0;
    tw_addr = 3'd0;
    case (stg)
      2'd0: begin
        top     = {bfl, 1'b0};
        bot     = top + 3'd1;
        tw_addr = 3'd0;
      end
      2'd1: begin
        top     = {bfl[1], 1'b0, bfl[0]};
        bot     = top + 3'd2;
        tw_addr = {1'b0, bfl[0], 1'b0};
      end
      default: begin
        top     = {1'b0, bfl};
        bot     = top + 3'd4;
        tw_addr = {1'b0, bfl};
      end
    endcase
  end

  // Twiddle ROM pair: W8^k = exp(-j*2*pi*k/8) scaled by 1000.
  always_comb begin
    tw_re = 16'sd1000;
    tw_im = 16'sd0;
    case (tw_addr)
      3'd0: begin tw_re =  16'sd1000; tw_im =  16'sd0;    end
      3'd1: begin tw_re =  16'sd707;  tw_im = -16'sd707;  end
      3'd2: begin tw_re =  16'sd0;    tw_im = -16'sd1000; end
      3'd3: begin tw_re = -16'sd707;  tw_im = -16'sd707;  end
      3'd4: begin tw_re = -16'sd1000; tw_im =  16'sd0;    end
      3'd5: begin tw_re = -16'sd707;  tw_im =  16'sd707;  end
      3'd6: begin tw_re =  16'sd0;    tw_im =  16'sd1000; end
      default: begin tw_re = 16'sd707; tw_im = 16'sd707;  end
    endcase
  end

  // Complex multiply of the bottom operand by the twiddle, one divide per component.
  always_comb begin
    a_re   = mem_re[top];
    a_im   = mem_im[top];
    b_re   = mem_re[bot];
    b_im   = mem_im[bot];
    br_x   = {{(IW-BW){b_re[BW-1]}}, b_re};
    bi_x   = {{(IW-BW){b_im[BW-1]}}, b_im};
    wr_x   = {{(IW-16){tw_re[15]}}, tw_re};
    wi_x   = {{(IW-16){tw_im[15]}}, tw_im};
    sum_re = br_x * wr_x - bi_x * wi_x;
    sum_im = br_x * wi_x + bi_x * wr_x;
    t_re   = BW'(sum_re / SCALE);
    t_im   = BW'(sum_im / SCALE);
  end

  // Control FSM: LOAD -> COMPUTE (12 butterflies) -> UNLOAD -> LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      cnt   <= 3'd0;
      stg   <= 2'd0;
      bfl   <= 2'd0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          bfl <= bfl + 2'd1;
          if (bfl == 2'd3) begin
            if (stg == 2'd2) begin
              stg   <= 2'd0;
              state <= UNLOAD;
            end else begin
              stg <= stg + 2'd1;
            end
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Sample buffer: not reset, every slot is rewritten during LOAD before use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD && in_valid) begin
        mem_re[ld_addr] <= {{3{in_re[DATA_W-1]}}, in_re};
        mem_im[ld_addr] <= {{3{in_im[DATA_W-1]}}, in_im};
      end else if (state == COMPUTE) begin
        mem_re[top] <= a_re + t_re;
        mem_im[top] <= a_im + t_im;
        mem_re[bot] <= a_re - t_re;
        mem_im[bot] <= a_im - t_im;
      end
    end
  end

endmodule
